// File: rtl/spark_ram.sv
// 256x8 big-endian data memory with mfa/mfc handshake; byte, half, word and
// two-beat double-word transfers over a 32-bit bus, all addresses wrap mod 256.
module spark_ram (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] DataOut,
  output logic        mfc,
  input  logic [7:0]  Address,
  input  logic [31:0] DataIn,
  input  logic        rw,
  input  logic        mfa,
  input  logic [1:0]  ByteMode
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DONE  = 2'd1;
  localparam logic [1:0] ST_DW1   = 2'd2;
  localparam logic [1:0] ST_DWGAP = 2'd3;

  localparam logic [1:0] MODE_WORD  = 2'b00;
  localparam logic [1:0] MODE_BYTE  = 2'b01;
  localparam logic [1:0] MODE_HALF  = 2'b10;
  localparam logic [1:0] MODE_DWORD = 2'b11;

  logic [7:0]  mem [256];

  logic [1:0]  state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] dout_q, dout_d;

  logic        beat_en;
  logic        beat_wr;
  logic [7:0]  beat_addr;
  logic [1:0]  beat_mode;
  logic [7:0]  lane_addr [4];
  logic [7:0]  lane_wdata [4];
  logic [3:0]  lane_mask;
  logic [3:0]  lane_we;
  logic [31:0] rdata;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    beat_en   = 1'b0;
    beat_wr   = rw;
    beat_addr = Address;
    beat_mode = ByteMode;
    case (state_q)
      ST_IDLE: begin
        if (mfa) begin
          addr_d  = Address;
          rw_d    = rw;
          beat_en = 1'b1;
          state_d = (ByteMode == MODE_DWORD) ? ST_DW1 : ST_DONE;
        end
      end
      ST_DONE:  if (!mfa) state_d = ST_IDLE;
      ST_DW1:   state_d = mfa ? ST_DWGAP : ST_IDLE;
      ST_DWGAP: begin
        if (mfa) begin
          beat_en   = 1'b1;
          beat_wr   = rw_q;
          beat_addr = addr_q + 8'd4;
          beat_mode = MODE_WORD;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane k addresses byte A+k; lane 0 always carries the most-significant byte.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k]  = beat_addr + 8'(k);
      lane_wdata[k] = 8'h00;
    end
    case (beat_mode)
      MODE_BYTE: begin
        lane_wdata[0] = DataIn[7:0];
        lane_mask     = 4'b0001;
        rdata         = {24'h0, mem[lane_addr[0]]};
      end
      MODE_HALF: begin
        lane_wdata[0] = DataIn[15:8];
        lane_wdata[1] = DataIn[7:0];
        lane_mask     = 4'b0011;
        rdata         = {16'h0, mem[lane_addr[0]], mem[lane_addr[1]]};
      end
      default: begin
        lane_wdata[0] = DataIn[31:24];
        lane_wdata[1] = DataIn[23:16];
        lane_wdata[2] = DataIn[15:8];
        lane_wdata[3] = DataIn[7:0];
        lane_mask     = 4'b1111;
        rdata         = {mem[lane_addr[0]], mem[lane_addr[1]],
                         mem[lane_addr[2]], mem[lane_addr[3]]};
      end
    endcase
    lane_we = (beat_en && beat_wr && rst_n) ? lane_mask : 4'b0000;
    dout_d  = (beat_en && !beat_wr) ? rdata : dout_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 8'h00;
      rw_q    <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      dout_q  <= dout_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive rst_n and only writes are gated.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) mem[lane_addr[k]] <= lane_wdata[k];
    end
  end

  assign mfc     = (state_q == ST_DONE) || (state_q == ST_DW1);
  assign DataOut = dout_q;

endmodule

// File: tb/tb_spark_ram.sv
// Randomized self-checking bench for spark_ram against a byte-array model of
// the big-endian memory and the mfa/mfc cycle pattern.
module tb_spark_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] DataOut;
  logic        mfc;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic        rw;
  logic        mfa;
  logic [1:0]  ByteMode;

  logic [7:0]  ref_mem [256];
  logic [31:0] exp_dout;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  spark_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .DataOut  (DataOut),
    .mfc      (mfc),
    .Address  (Address),
    .DataIn   (DataIn),
    .rw       (rw),
    .mfa      (mfa),
    .ByteMode (ByteMode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] m);
    case (m)
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [7:0] a, input int n);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[8'(int'(a) + i)]);
    return v;
  endfunction

  task automatic ref_write(input logic [7:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) ref_mem[8'(int'(a) + i)] = d[8*(n-1-i) +: 8];
  endtask

  // One complete transaction; hold = extra cycles mfa stays high in DONE,
  // abort = drop mfa during DW1 of a double-word.
  task automatic access(input logic w, input logic [1:0] m, input logic [7:0] a,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int hold, input bit abort);
    bit dw = (m == 2'b11);
    @(negedge clk);
    mfa = 1'b1; rw = w; ByteMode = m; Address = a; DataIn = d0;
    @(posedge clk); #1;
    if (w) ref_write(a, nbytes(m), d0);
    else   exp_dout = ref_read(a, nbytes(m));
    check("mfc_e0", 32'(mfc), 32'd1);
    check("dout_e0", DataOut, exp_dout);
    @(negedge clk);
    Address = 8'($urandom); rw = 1'($urandom); ByteMode = 2'($urandom); DataIn = d1;
    if (dw) begin
      if (abort) mfa = 1'b0;
      @(posedge clk); #1;
      check("mfc_dw1", 32'(mfc), 32'd0);
      check("dout_dw1", DataOut, exp_dout);
      if (!abort) begin
        @(negedge clk);
        @(posedge clk); #1;
        if (w) ref_write(8'(a + 8'd4), 4, d1);
        else   exp_dout = ref_read(8'(a + 8'd4), 4);
        check("mfc_e2", 32'(mfc), 32'd1);
        check("dout_e2", DataOut, exp_dout);
        @(negedge clk);
      end
    end
    if (!(dw && abort)) begin
      for (int h = 0; h < hold; h++) begin
        Address = 8'($urandom); DataIn = $urandom;
        @(posedge clk); #1;
        check("mfc_hold", 32'(mfc), 32'd1);
        check("dout_hold", DataOut, exp_dout);
        @(negedge clk);
      end
      mfa = 1'b0;
      @(posedge clk); #1;
      check("mfc_release", 32'(mfc), 32'd0);
      check("dout_release", DataOut, exp_dout);
    end
  endtask

  initial begin
    rst_n = 1'b0; mfa = 1'b0; rw = 1'b0; ByteMode = 2'b00; Address = 8'h0; DataIn = 32'h0;
    exp_dout = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mfc", 32'(mfc), 32'd0);
    check("reset_dout", DataOut, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill memory so every later read has a defined expected value.
    for (int i = 0; i < 64; i++) access(1'b1, 2'b00, 8'(i * 4), $urandom, 32'h0, 0, 1'b0);

    // Word write/read
    access(1'b1, 2'b00, 8'd68, 32'hE5C15003, 32'h0, 0, 1'b0);
    access(1'b0, 2'b00, 8'd68, 32'h0, 32'h0, 1, 1'b0);
    check("word68", DataOut, 32'hE5C15003);
    // Byte over a zeroed word
    access(1'b1, 2'b00, 8'd60, 32'h0, 32'h0, 0, 1'b0);
    access(1'b1, 2'b01, 8'd60, 32'h123456CC, 32'h0, 0, 1'b0);
    access(1'b0, 2'b01, 8'd60, 32'h0, 32'h0, 0, 1'b0);
    check("byte60", DataOut, 32'h000000CC);
    access(1'b0, 2'b00, 8'd60, 32'h0, 32'h0, 0, 1'b0);
    check("word60", DataOut, 32'hCC000000);
    // Half-word
    access(1'b1, 2'b10, 8'd64, 32'h9999AAF0, 32'h0, 0, 1'b0);
    access(1'b0, 2'b10, 8'd64, 32'h0, 32'h0, 0, 1'b0);
    check("half64", DataOut, 32'h0000AAF0);
    access(1'b0, 2'b01, 8'd65, 32'h0, 32'h0, 0, 1'b0);
    check("byte65", DataOut, 32'h000000F0);
    // Double-word write then reads
    access(1'b1, 2'b11, 8'd72, 32'hE5C15003, 32'h0B050704, 0, 1'b0);
    access(1'b0, 2'b00, 8'd72, 32'h0, 32'h0, 0, 1'b0);
    check("word72", DataOut, 32'hE5C15003);
    access(1'b0, 2'b00, 8'd76, 32'h0, 32'h0, 0, 1'b0);
    check("word76", DataOut, 32'h0B050704);
    access(1'b0, 2'b11, 8'd72, 32'h0, 32'h0, 2, 1'b0);
    check("dword72_b2", DataOut, 32'h0B050704);
    // Wrap-around
    access(1'b1, 2'b11, 8'd252, 32'h11223344, 32'h55667788, 0, 1'b0);
    access(1'b0, 2'b00, 8'd0, 32'h0, 32'h0, 0, 1'b0);
    check("wrap_word0", DataOut, 32'h55667788);
    access(1'b1, 2'b10, 8'd255, 32'h0000ABCD, 32'h0, 0, 1'b0);
    access(1'b0, 2'b01, 8'd255, 32'h0, 32'h0, 0, 1'b0);
    check("wrap_byte255", DataOut, 32'h000000AB);
    access(1'b0, 2'b01, 8'd0, 32'h0, 32'h0, 0, 1'b0);
    check("wrap_byte0", DataOut, 32'h000000CD);

    // Reset during DWGAP of a double-word write: beat 2 must not land.
    @(negedge clk);
    mfa = 1'b1; rw = 1'b1; ByteMode = 2'b11; Address = 8'd100; DataIn = 32'hA1A2A3A4;
    @(posedge clk); #1;
    ref_write(8'd100, 4, 32'hA1A2A3A4);
    check("rst_dw_mfc_e0", 32'(mfc), 32'd1);
    @(negedge clk);
    DataIn = 32'hB1B2B3B4;
    @(posedge clk); #1;
    check("rst_dw_mfc_gap", 32'(mfc), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_dout = 32'h0;
    check("rst_dw_mfc", 32'(mfc), 32'd0);
    check("rst_dw_dout", DataOut, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mfa = 1'b0;
    access(1'b0, 2'b00, 8'd100, 32'h0, 32'h0, 0, 1'b0);
    check("rst_dw_beat1", DataOut, 32'hA1A2A3A4);
    access(1'b0, 2'b00, 8'd104, 32'h0, 32'h0, 0, 1'b0);

    // Randomized mix including aborted double-words and long mfa holds.
    for (int i = 0; i < 300; i++) begin
      access(1'($urandom), 2'($urandom), 8'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
    end

    // Final sweep of the whole array.
    for (int i = 0; i < 64; i++) access(1'b0, 2'b00, 8'(i * 4), 32'h0, 32'h0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
